// File: rtl/pb_ctrl_pkg.sv
// pb_ctrl_pkg: shared state type, counter sizing and default constants
// for the time-multiplexed pushbutton controller.
package pb_ctrl_pkg;
   typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} pb_state_t;
   localparam int DEF_NUM_PB       = 4;
   localparam int DEF_TICK_DIV     = 50000;
   localparam int DEF_DEB_SAMPLES  = 10;
   localparam int DEF_REPEAT_DELAY = 250;
   localparam int DEF_REPEAT_RATE  = 50;
   function automatic int cnt_width(input int deb, input int rpt);
      return $clog2(deb > rpt ? deb : rpt);
   endfunction
endpackage

// File: rtl/pb_scan_ctrl_if.sv
// pb_scan_ctrl_if: button inputs, scan enable and per-button debounced outputs.
interface pb_scan_ctrl_if
   import pb_ctrl_pkg::*;
#(parameter int NUM_PB = DEF_NUM_PB);
   logic              en;
   logic [NUM_PB-1:0] pb_in;
   logic [NUM_PB-1:0] pb_level;
   logic [NUM_PB-1:0] pb_press;
   logic [NUM_PB-1:0] pb_release;
   logic [NUM_PB-1:0] pb_repeat;
   modport master (output en, pb_in, input pb_level, pb_press, pb_release, pb_repeat);
   modport slave (input en, pb_in, output pb_level, pb_press, pb_release, pb_repeat);
endinterface

// File: rtl/pb_scan_fsm.sv
// pb_scan_fsm: combinational debounce/auto-repeat step for the button being visited.
module pb_scan_fsm
   import pb_ctrl_pkg::*;
#(
   parameter int DEB_SAMPLES  = DEF_DEB_SAMPLES,
   parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
   parameter int REPEAT_RATE  = DEF_REPEAT_RATE,
   parameter int CW           = cnt_width(DEB_SAMPLES, REPEAT_DELAY)
) (
   input  logic          p,
   input  pb_state_t     state,
   input  logic [CW-1:0] cnt,
   output pb_state_t     nstate,
   output logic [CW-1:0] ncnt,
   output logic          press,
   output logic          rel,
   output logic          rpt
);
   localparam logic [CW-1:0] DEB_LAST   = CW'(DEB_SAMPLES - 1);
   localparam logic [CW-1:0] RPT_LAST   = CW'(REPEAT_DELAY - 1);
   localparam logic [CW-1:0] RPT_RELOAD = CW'(REPEAT_DELAY - REPEAT_RATE);
   always_comb begin
      nstate = state;
      ncnt   = cnt + 1'b1;
      press  = 1'b0;
      rel    = 1'b0;
      rpt    = 1'b0;
      case (state)
         IDLE: begin
            nstate = p ? PRESS_WAIT : IDLE;
            ncnt   = p ? CW'(1) : '0;
         end
         PRESS_WAIT:
            if (!p) begin
               nstate = IDLE;
               ncnt   = '0;
            end else if (cnt == DEB_LAST) begin
               nstate = HELD;
               ncnt   = '0;
               press  = 1'b1;
            end
         HELD:
            if (!p) begin
               nstate = RELEASE_WAIT;
               ncnt   = CW'(1);
            end else if (cnt == RPT_LAST) begin
               ncnt = RPT_RELOAD;
               rpt  = 1'b1;
            end
         // a bounce back to pressed restarts the repeat timer without a pulse
         RELEASE_WAIT:
            if (p) begin
               nstate = HELD;
               ncnt   = '0;
            end else if (cnt == DEB_LAST) begin
               nstate = IDLE;
               ncnt   = '0;
               rel    = 1'b1;
            end
         default: begin
            nstate = IDLE;
            ncnt   = '0;
         end
      endcase
   end
endmodule

// File: rtl/pb_scan_ctrl.sv
// pb_scan_ctrl: synchronises all buttons and services one per scan tick through
// a single shared debounce/auto-repeat datapath.
module pb_scan_ctrl
   import pb_ctrl_pkg::*;
#(
   parameter int NUM_PB       = DEF_NUM_PB,
   parameter int TICK_DIV     = DEF_TICK_DIV,
   parameter int DEB_SAMPLES  = DEF_DEB_SAMPLES,
   parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
   parameter int REPEAT_RATE  = DEF_REPEAT_RATE
) (
   input logic           in_clk,
   input logic           in_rst_n,
   pb_scan_ctrl_if.slave bus
);
   localparam int CW = cnt_width(DEB_SAMPLES, REPEAT_DELAY);
   localparam int DW = $clog2(TICK_DIV);
   localparam int IW = $clog2(NUM_PB);
   logic [NUM_PB-1:0] sync1, sync2, level, press, rel, rpt;
   logic [DW-1:0]     div;
   logic [IW-1:0]     idx;
   pb_state_t         st [NUM_PB];
   logic [CW-1:0]     cnt [NUM_PB];
   pb_state_t         nst;
   logic [CW-1:0]     ncnt;
   logic              tick, f_press, f_rel, f_rpt;
   assign tick = bus.en && div == DW'(TICK_DIV - 1);
   pb_scan_fsm #(
      .DEB_SAMPLES (DEB_SAMPLES),
      .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_RATE (REPEAT_RATE),
      .CW          (CW)
   ) u_fsm (
      .p     (~sync2[idx]),
      .state (st[idx]),
      .cnt   (cnt[idx]),
      .nstate(nst),
      .ncnt  (ncnt),
      .press (f_press),
      .rel   (f_rel),
      .rpt   (f_rpt)
   );
   // synchronisers reset to 1 so a released button is seen during reset recovery
   always_ff @(posedge in_clk or negedge in_rst_n)
      if (!in_rst_n) begin
         sync1 <= '1;
         sync2 <= '1;
         div   <= '0;
         idx   <= '0;
         level <= '0;
         press <= '0;
         rel   <= '0;
         rpt   <= '0;
         st    <= '{default: IDLE};
         cnt   <= '{default: '0};
      end else begin
         sync1 <= bus.pb_in;
         sync2 <= sync1;
         press <= '0;
         rel   <= '0;
         rpt   <= '0;
         if (bus.en) div <= tick ? '0 : div + 1'b1;
         if (tick) begin
            idx        <= idx == IW'(NUM_PB - 1) ? '0 : idx + 1'b1;
            st[idx]    <= nst;
            cnt[idx]   <= ncnt;
            press[idx] <= f_press;
            rel[idx]   <= f_rel;
            rpt[idx]   <= f_rpt;
            level[idx] <= f_press | (level[idx] & ~f_rel);
         end
      end
   assign bus.pb_level   = level;
   assign bus.pb_press   = press;
   assign bus.pb_release = rel;
   assign bus.pb_repeat  = rpt;
endmodule

// File: tb/tb_pb_scan_ctrl.sv
// tb_pb_scan_ctrl: directed bench; visit period is 16 cycles with TICK_DIV=4, NUM_PB=4.
module tb_pb_scan_ctrl;
   localparam int NPB = 4;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   compared = 0;
   int   mismatched = 0;
   pb_scan_ctrl_if #(.NUM_PB(NPB)) bus ();
   pb_scan_ctrl #(
      .NUM_PB(NPB), .TICK_DIV(4), .DEB_SAMPLES(3), .REPEAT_DELAY(5), .REPEAT_RATE(2)
   ) dut (
      .in_clk  (clk),
      .in_rst_n(rst_n),
      .bus     (bus.slave)
   );
   always #5 clk = ~clk;

   task automatic do_reset(input logic [NPB-1:0] pins);
      rst_n = 1'b0;
      bus.en = 1'b1;
      bus.pb_in = pins;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset;
      logic [NPB-1:0] any;
      any = '0;
      rst_n = 1'b0;
      bus.en = 1'b1;
      bus.pb_in = '0;
      repeat (5) @(posedge clk);
      #1;
      compared++;
      if (bus.pb_level !== 4'b0000) begin mismatched++; $display("FAIL reset_level: got %b want 0000", bus.pb_level); end
      compared++;
      if (bus.pb_press !== 4'b0000) begin mismatched++; $display("FAIL reset_press: got %b want 0000", bus.pb_press); end
      compared++;
      if (bus.pb_release !== 4'b0000) begin mismatched++; $display("FAIL reset_release: got %b want 0000", bus.pb_release); end
      compared++;
      if (bus.pb_repeat !== 4'b0000) begin mismatched++; $display("FAIL reset_repeat: got %b want 0000", bus.pb_repeat); end
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 1; c <= 35; c++) begin
         @(posedge clk); #1;
         any |= bus.pb_press | bus.pb_release | bus.pb_repeat | bus.pb_level;
      end
      compared++;
      if (any !== 4'b0000) begin mismatched++; $display("FAIL reset_exit_quiet: got %b want 0000", any); end
   endtask

   task automatic test_press_repeat;
      int pc[$];
      int rc[$];
      int lc[$];
      logic [NPB-1:0] other, lv35, lv37, lv227, lv229;
      other = '0;
      do_reset(4'b1110);
      for (int c = 1; c <= 240; c++) begin
         @(posedge clk); #1;
         if (bus.pb_press[0]) pc.push_back(c);
         if (bus.pb_repeat[0]) rc.push_back(c);
         if (bus.pb_release[0]) lc.push_back(c);
         other |= (bus.pb_press | bus.pb_repeat | bus.pb_release | bus.pb_level) & 4'b1110;
         if (c == 35) lv35 = bus.pb_level;
         if (c == 37) lv37 = bus.pb_level;
         if (c == 227) lv227 = bus.pb_level;
         if (c == 229) lv229 = bus.pb_level;
         if (c == 180) bus.pb_in = 4'b1111;
      end
      compared++;
      if (!(pc.size() == 1 && pc[0] == 36)) begin
         mismatched++;
         $display("FAIL press_cycle: got n=%0d first=%0d want n=1 at 36", pc.size(), pc.size() > 0 ? pc[0] : -1);
      end
      compared++;
      if (lv35 !== 4'b0000 || lv37 !== 4'b0001) begin mismatched++; $display("FAIL press_level: got %b/%b want 0000/0001", lv35, lv37); end
      compared++;
      if (!(rc.size() == 3 && rc[0] == 116 && rc[1] == 148 && rc[2] == 180)) begin
         mismatched++;
         $display("FAIL repeat_cycles: got n=%0d first=%0d want n=3 at 116,148,180", rc.size(), rc.size() > 0 ? rc[0] : -1);
      end
      compared++;
      if (!(lc.size() == 1 && lc[0] == 228)) begin
         mismatched++;
         $display("FAIL release_cycle: got n=%0d first=%0d want n=1 at 228", lc.size(), lc.size() > 0 ? lc[0] : -1);
      end
      compared++;
      if (lv227 !== 4'b0001 || lv229 !== 4'b0000) begin mismatched++; $display("FAIL release_level: got %b/%b want 0001/0000", lv227, lv229); end
      compared++;
      if (other !== 4'b0000) begin mismatched++; $display("FAIL press_other_bits: got %b want 0000", other); end
   endtask

   task automatic test_bounce;
      logic [NPB-1:0] any;
      any = '0;
      do_reset(4'b1111);
      for (int c = 1; c <= 100; c++) begin
         @(posedge clk); #1;
         any |= bus.pb_press | bus.pb_level;
         if (c == 1) bus.pb_in[1] = 1'b0;
         if (c == 6) bus.pb_in[1] = 1'b1;
         if (c == 26) bus.pb_in[1] = 1'b0;
         if (c == 32) bus.pb_in[1] = 1'b1;
      end
      compared++;
      if (any !== 4'b0000) begin mismatched++; $display("FAIL bounce_rejected: got %b want 0000", any); end
   endtask

   task automatic test_all_press;
      int fp[NPB];
      int multi;
      multi = 0;
      for (int k = 0; k < NPB; k++) fp[k] = -1;
      do_reset(4'b0000);
      for (int c = 1; c <= 60; c++) begin
         @(posedge clk); #1;
         if ($countones(bus.pb_press) > 1) multi++;
         for (int k = 0; k < NPB; k++)
            if (bus.pb_press[k] && fp[k] < 0) fp[k] = c;
      end
      for (int k = 0; k < NPB; k++) begin
         compared++;
         if (fp[k] != 36 + 4 * k) begin mismatched++; $display("FAIL all_press_bit%0d: got cycle %0d want %0d", k, fp[k], 36 + 4 * k); end
      end
      compared++;
      if (multi != 0) begin mismatched++; $display("FAIL all_press_overlap: got %0d cycles want 0", multi); end
      compared++;
      if (bus.pb_level !== 4'b1111) begin mismatched++; $display("FAIL all_press_level: got %b want 1111", bus.pb_level); end
   endtask

   task automatic test_reset_mid;
      int pc[$];
      int early;
      early = 0;
      rst_n = 1'b0;
      #1;
      compared++;
      if (bus.pb_level !== 4'b0000) begin mismatched++; $display("FAIL async_reset_level: got %b want 0000", bus.pb_level); end
      repeat (3) @(posedge clk);
      bus.pb_in = 4'b1110;
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 1; c <= 30; c++) begin
         @(posedge clk); #1;
         if (bus.pb_press != 4'b0000) early++;
      end
      compared++;
      if (early != 0) begin mismatched++; $display("FAIL mid_early_press: got %0d want 0", early); end
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      compared++;
      if ((bus.pb_level | bus.pb_press | bus.pb_release | bus.pb_repeat) !== 4'b0000) begin
         mismatched++;
         $display("FAIL mid_reset_outputs: got %b want 0000", bus.pb_level | bus.pb_press | bus.pb_release | bus.pb_repeat);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 1; c <= 40; c++) begin
         @(posedge clk); #1;
         if (bus.pb_press[0]) pc.push_back(c);
      end
      compared++;
      if (!(pc.size() == 1 && pc[0] == 36)) begin
         mismatched++;
         $display("FAIL mid_reset_press: got n=%0d first=%0d want n=1 at 36", pc.size(), pc.size() > 0 ? pc[0] : -1);
      end
   endtask

   task automatic test_enable;
      int pc[$];
      int rc[$];
      int frozen;
      frozen = 0;
      do_reset(4'b1110);
      for (int c = 1; c <= 200; c++) begin
         @(posedge clk); #1;
         if (bus.pb_press[0]) pc.push_back(c);
         if (bus.pb_repeat[0]) rc.push_back(c);
         if (c > 60 && c <= 101 && (bus.pb_press | bus.pb_release | bus.pb_repeat) != 4'b0000) frozen++;
         if (c == 60) bus.en = 1'b0;
         if (c == 100) bus.en = 1'b1;
      end
      compared++;
      if (!(pc.size() == 1 && pc[0] == 36)) begin
         mismatched++;
         $display("FAIL en_press: got n=%0d first=%0d want n=1 at 36", pc.size(), pc.size() > 0 ? pc[0] : -1);
      end
      compared++;
      if (frozen != 0) begin mismatched++; $display("FAIL en_frozen_pulses: got %0d want 0", frozen); end
      compared++;
      if (!(rc.size() == 2 && rc[0] == 156 && rc[1] == 188)) begin
         mismatched++;
         $display("FAIL en_repeat_cycles: got n=%0d first=%0d want n=2 at 156,188", rc.size(), rc.size() > 0 ? rc[0] : -1);
      end
   endtask

   initial begin
      test_reset;
      test_press_repeat;
      test_bounce;
      test_all_press;
      test_reset_mid;
      test_enable;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
